// File: rtl/pico_mips.sv
// picoMIPS: single-cycle 8-bit CPU running a fixed ROM program that computes a 2-D
// affine transform of two switch-entered signed inputs and shows the results on LED.
module pico_mips #(
  parameter int SWITCH_WIDTH = 10,
  parameter int LED_WIDTH    = 8,
  parameter int PC_WIDTH     = 5,
  parameter int INSTR_WIDTH  = 17
) (
  input  logic                    clk,
  input  logic [SWITCH_WIDTH-1:0] SW,
  output logic [LED_WIDTH-1:0]    LED
);

  typedef enum logic [2:0] {
    OP_WAIT1 = 3'd0,
    OP_WAIT0 = 3'd1,
    OP_IN    = 3'd2,
    OP_OUT   = 3'd3,
    OP_ADD   = 3'd4,
    OP_ADDI  = 3'd5,
    OP_MULI  = 3'd6,
    OP_JMP   = 3'd7
  } op_e;

  localparam int SYNC_W = SWITCH_WIDTH - 1;

  logic                   rst_n;
  logic [SYNC_W-1:0]      sync1_q, sync2_q;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [LED_WIDTH-1:0]   led_q, led_d;
  logic [LED_WIDTH-1:0]   regs_q [8];
  logic [INSTR_WIDTH-1:0] instr;
  op_e                    op;
  logic [2:0]             rd, rs;
  logic [LED_WIDTH-1:0]   imm, rd_val, rs_val, wr_data;
  logic                   wr_en;
  logic                   sw_hs;
  logic [LED_WIDTH-1:0]   sw_data;
  logic signed [2*LED_WIDTH-1:0] prod;

  assign rst_n   = SW[SWITCH_WIDTH-1];
  assign sw_hs   = sync2_q[SYNC_W-1];
  assign sw_data = sync2_q[LED_WIDTH-1:0];

  function automatic logic [INSTR_WIDTH-1:0] enc(input op_e o, input logic [2:0] d,
                                                 input logic [2:0] s,
                                                 input logic [LED_WIDTH-1:0] i);
    return {o, d, s, i};
  endfunction

  // Multiplier immediates are signed Q0.7: 64 = 0.5, -112 = -0.875, 96 = 0.75.
  always_comb begin
    case (pc_q)
      5'd0:    instr = enc(OP_WAIT1, 3'd0, 3'd0, 8'd0);
      5'd1:    instr = enc(OP_IN,    3'd1, 3'd0, 8'd0);
      5'd2:    instr = enc(OP_WAIT0, 3'd0, 3'd0, 8'd0);
      5'd3:    instr = enc(OP_WAIT1, 3'd0, 3'd0, 8'd0);
      5'd4:    instr = enc(OP_IN,    3'd2, 3'd0, 8'd0);
      5'd5:    instr = enc(OP_WAIT0, 3'd0, 3'd0, 8'd0);
      5'd6:    instr = enc(OP_MULI,  3'd3, 3'd1, 8'd64);
      5'd7:    instr = enc(OP_MULI,  3'd4, 3'd2, 8'(-112));
      5'd8:    instr = enc(OP_ADD,   3'd3, 3'd4, 8'd0);
      5'd9:    instr = enc(OP_ADDI,  3'd3, 3'd3, 8'd5);
      5'd10:   instr = enc(OP_OUT,   3'd0, 3'd3, 8'd0);
      5'd11:   instr = enc(OP_MULI,  3'd5, 3'd1, 8'(-112));
      5'd12:   instr = enc(OP_MULI,  3'd6, 3'd2, 8'd96);
      5'd13:   instr = enc(OP_ADD,   3'd5, 3'd6, 8'd0);
      5'd14:   instr = enc(OP_ADDI,  3'd5, 3'd5, 8'd12);
      5'd15:   instr = enc(OP_WAIT1, 3'd0, 3'd0, 8'd0);
      5'd16:   instr = enc(OP_OUT,   3'd0, 3'd5, 8'd0);
      5'd17:   instr = enc(OP_WAIT0, 3'd0, 3'd0, 8'd0);
      default: instr = enc(OP_JMP,   3'd0, 3'd0, 8'd0);
    endcase
  end

  assign op  = op_e'(instr[INSTR_WIDTH-1 -: 3]);
  assign rd  = instr[INSTR_WIDTH-4 -: 3];
  assign rs  = instr[INSTR_WIDTH-7 -: 3];
  assign imm = instr[LED_WIDTH-1:0];

  assign rd_val = (rd == 3'd0) ? '0 : regs_q[rd];
  assign rs_val = (rs == 3'd0) ? '0 : regs_q[rs];
  assign prod   = $signed(rs_val) * $signed(imm);

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    pc_d    = pc_q + 1'b1;
    led_d   = led_q;
    wr_en   = 1'b0;
    wr_data = rs_val;
    case (op)
      OP_WAIT1: if (!sw_hs) pc_d = pc_q;
      OP_WAIT0: if (sw_hs)  pc_d = pc_q;
      OP_IN:    begin wr_en = 1'b1; wr_data = sw_data;           end
      OP_OUT:   led_d = rs_val;
      OP_ADD:   begin wr_en = 1'b1; wr_data = rd_val + rs_val;   end
      OP_ADDI:  begin wr_en = 1'b1; wr_data = rs_val + imm;      end
      // Arithmetic shift floors toward -infinity; the kept byte is product bits [14:7].
      OP_MULI:  begin wr_en = 1'b1; wr_data = LED_WIDTH'(prod >>> (LED_WIDTH-1)); end
      OP_JMP:   pc_d = imm[PC_WIDTH-1:0];
      default:  ;
    endcase
  end

  // NOTE: the register file is eight flops that must read zero after reset, so it is
  // reset like any other state rather than treated as an unreset RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pc_q    <= '0;
      led_q   <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      sync1_q <= SW[SYNC_W-1:0];
      sync2_q <= sync1_q;
      pc_q    <= pc_d;
      led_q   <= led_d;
      if (wr_en && rd != 3'd0) regs_q[rd] <= wr_data;
    end
  end

  assign LED = led_q;

endmodule

// File: tb/tb_pico_mips.sv
// Directed bench for pico_mips: drives the operator handshake and checks LED against
// an arithmetic model of the affine transform on every settled cycle.
module tb_pico_mips;

  logic       clk = 1'b0;
  logic [9:0] SW  = 10'h000;
  logic [7:0] LED;

  int         n_checks = 0;
  int         n_errors = 0;
  logic       settled  = 1'b0;
  logic [7:0] exp_led  = 8'd0;
  logic [7:0] exp_prev = 8'd0;
  string      phase    = "idle";

  always #10 clk = ~clk;

  pico_mips dut (
    .clk (clk),
    .SW  (SW),
    .LED (LED)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%02h), required %0d (0x%02h)",
               name, $signed(act), act, $signed(req), req);
    end
  endtask

  // Floor division, so the model rounds toward -infinity like the real-number spec.
  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q--;
    return q;
  endfunction

  function automatic logic [7:0] model_x(input int x, input int y);
    return 8'(fdiv(64 * x, 128) + fdiv(-112 * y, 128) + 5);
  endfunction

  function automatic logic [7:0] model_y(input int x, input int y);
    return 8'(fdiv(-112 * x, 128) + fdiv(96 * y, 128) + 12);
  endfunction

  always @(negedge clk) begin
    if (settled) check({"track_", phase}, LED, exp_led);
  end

  // One handshake edge, then a 12-clock latency window before LED must hold exp.
  task automatic step(input bit level, input logic [7:0] exp, input string nm);
    @(negedge clk);
    settled = 1'b0;
    SW[8]   = level;
    phase   = nm;
    repeat (12) @(posedge clk);
    exp_led = exp;
    settled = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic transform(input int x, input int y, input logic [7:0] ex,
                           input logic [7:0] ey, input bit scramble);
    @(negedge clk);
    SW[7:0] = 8'(x);
    step(1'b1, exp_prev, "x_hi");
    if (scramble) SW[7:0] = 8'($urandom);
    step(1'b0, exp_prev, "x_lo");
    if (scramble) SW[7:0] = 8'($urandom);
    @(negedge clk);
    SW[7:0] = 8'(y);
    step(1'b1, exp_prev, "y_hi");
    if (scramble) SW[7:0] = 8'($urandom);
    step(1'b0, ex, "xprime");
    if (scramble) SW[7:0] = 8'($urandom);
    step(1'b1, ey, "yprime");
    step(1'b0, ey, "restart");
    exp_prev = ey;
  endtask

  int xs [9] = '{-128, -127, -65, -1, 0, 1, 63, 100, 127};
  int ys [9] = '{-128, -100, -64, -2, 0, 2, 31, 126, 127};

  initial begin
    // Pin the model with hand-computed results.
    check("model_x_m1_2",     model_x(-1, 2),     8'd2);
    check("model_y_m1_2",     model_y(-1, 2),     8'd13);
    check("model_x_m128_127", model_x(-128, 127), 8'd85);
    check("model_y_m128_127", model_y(-128, 127), 8'(-37));
    check("model_x_0_0",      model_x(0, 0),      8'd5);
    check("model_y_0_0",      model_y(0, 0),      8'd12);

    repeat (3) @(negedge clk);
    check("reset_led", LED, 8'd0);
    SW[9]   = 1'b1;
    phase   = "after_reset";
    exp_led = 8'd0;
    settled = 1'b1;
    repeat (12) @(negedge clk);

    transform(-1,   2,   8'd2,  8'd13,    1'b0);
    transform(-128, 127, 8'd85, 8'(-37),  1'b0);
    transform(0,    0,   8'd5,  8'd12,    1'b0);

    // Switch data must only matter at IN.
    transform(37, -91, model_x(37, -91), model_y(37, -91), 1'b1);
    transform(-77, 55, model_x(-77, 55), model_y(-77, 55), 1'b1);

    // Reset in the middle of an entry: LED clears, next transform starts from x.
    @(negedge clk);
    SW[7:0] = 8'd50;
    step(1'b1, exp_prev, "rst_x_hi");
    step(1'b0, exp_prev, "rst_x_lo");
    @(negedge clk);
    settled = 1'b0;
    SW[7:0] = 8'hAA;
    SW[8]   = 1'b1;
    #3 SW[9] = 1'b0;
    #1 check("reset_mid_entry", LED, 8'd0);
    repeat (3) @(negedge clk);
    check("reset_held", LED, 8'd0);
    SW[8]    = 1'b0;
    SW[9]    = 1'b1;
    exp_prev = 8'd0;
    transform(3, -7, model_x(3, -7), model_y(3, -7), 1'b0);

    foreach (xs[i]) begin
      foreach (ys[j]) begin
        transform(xs[i], ys[j], model_x(xs[i], ys[j]), model_y(xs[i], ys[j]), 1'b0);
      end
    end

    settled = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
